// File: rtl/lcd_share_arbiter.sv
// lcd_share_arbiter: time-shares one lcd1602 driver between player and host frames with a minimum owner dwell
module lcd_share_arbiter #(
  parameter int DWELL_CYC = 12000000,
  parameter int ACK_TO = 15,
  parameter int CNT_W = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] play_row1,
  input  logic [127:0] play_row2,
  input  logic [127:0] host_row1,
  input  logic [127:0] host_row2,
  input  logic         play_upd,
  input  logic         host_upd,
  input  logic         lcd_busy,
  output logic [127:0] lcd_row1,
  output logic [127:0] lcd_row2,
  output logic         lcd_start,
  output logic         owner,
  output logic         play_pend,
  output logic         host_pend
);
  localparam int AW = $clog2(ACK_TO + 1);
  localparam logic [AW-1:0] ACK_LAST = AW'(ACK_TO);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DWELL_CYC - 1);
  localparam logic [127:0] SPACES = {16{8'h20}};
  typedef enum logic [2:0] {IDLE, LATCH, START, WAIT_ACK, DRAW, DWELL} state_t;
  state_t state, nxt;
  logic sel, sel_nxt, last_owner;
  logic [CNT_W-1:0] dwell;
  logic [AW-1:0] ack;
  logic latching;
  assign lcd_start = state == START;
  assign latching = state == LATCH;
  always_comb begin
    nxt = state;
    sel_nxt = sel;
    case (state)
      IDLE: if (play_pend | host_pend) begin
        nxt = LATCH;
        sel_nxt = (play_pend & host_pend) ? ~last_owner : host_pend;
      end
      LATCH:    nxt = START;
      START:    nxt = WAIT_ACK;
      WAIT_ACK: nxt = lcd_busy ? DRAW : (ack == ACK_LAST) ? START : WAIT_ACK;
      DRAW:     nxt = lcd_busy ? DRAW : DWELL;
      DWELL: if (owner ? host_pend : play_pend) begin
        nxt = LATCH;
        sel_nxt = owner;
      end else if (dwell == '0) nxt = IDLE;
      default:  nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sel <= 1'b0;
      owner <= 1'b0;
      last_owner <= 1'b1;
      play_pend <= 1'b0;
      host_pend <= 1'b0;
      lcd_row1 <= SPACES;
      lcd_row2 <= SPACES;
      dwell <= '0;
      ack <= '0;
    end else begin
      state <= nxt;
      sel <= sel_nxt;
      // an update arriving in its own latch cycle wins, so the newer frame is re-sent
      play_pend <= play_upd | (play_pend & ~(latching & ~sel));
      host_pend <= host_upd | (host_pend & ~(latching & sel));
      ack <= (state == START) ? '0 : (state == WAIT_ACK) ? ack + AW'(1) : ack;
      if (latching) begin
        lcd_row1 <= sel ? host_row1 : play_row1;
        lcd_row2 <= sel ? host_row2 : play_row2;
        owner <= sel;
      end
      // only a change of owner restarts the dwell; self-refreshes keep it running
      if (latching && sel != last_owner) begin
        last_owner <= sel;
        dwell <= RELOAD;
      end else if (state != IDLE && dwell != '0) dwell <= dwell - CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_lcd_share_arbiter.sv
// tb_lcd_share_arbiter: vector table plus directed multi-cycle sequences for lcd_share_arbiter
module tb_lcd_share_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic [127:0] play_row1 = "PLAYER-TOP------", play_row2 = "player-bottom---";
  logic [127:0] host_row1 = "HOST-TOP-AAAAAAA", host_row2 = "host-bottom-----";
  logic play_upd = 1'b0, host_upd = 1'b0, busy = 1'b0;
  logic [127:0] lcd_row1, lcd_row2;
  logic lcd_start, owner, play_pend, host_pend;
  logic resp_en = 1'b0;
  int checks = 0, errors = 0, cyc = 0;
  localparam logic [127:0] SP = {16{8'h20}};
  typedef struct {int t; logic ow; logic [127:0] r1;} ent_t;
  ent_t slog[$];
  typedef struct {int n; logic pu, hu, bz, st, ow, pp, hp; int rw;} vec_t;
  vec_t tbl[14];

  lcd_share_arbiter #(.DWELL_CYC(20), .ACK_TO(15), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .play_row1(play_row1), .play_row2(play_row2),
    .host_row1(host_row1), .host_row2(host_row2),
    .play_upd(play_upd), .host_upd(host_upd), .lcd_busy(busy),
    .lcd_row1(lcd_row1), .lcd_row2(lcd_row2), .lcd_start(lcd_start),
    .owner(owner), .play_pend(play_pend), .host_pend(host_pend)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (lcd_start) slog.push_back('{t: cyc, ow: owner, r1: lcd_row1});

  // driver model: busy rises 2 cycles after start and stays high 10 cycles
  initial forever begin
    @(negedge clk);
    if (lcd_start && resp_en) begin
      repeat (2) @(negedge clk);
      busy = 1'b1;
      repeat (10) @(negedge clk);
      busy = 1'b0;
    end
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic wait_log(input int n, input int lim, input string nm);
    int k = 0;
    while (slog.size() < n && k < lim) begin
      @(posedge clk);
      k++;
    end
    checks++;
    if (slog.size() < n) begin
      errors++;
      $display("FAIL %s: %0d starts seen, want %0d within %0d cycles", nm, slog.size(), n, lim);
    end
  endtask

  task automatic do_reset(input logic re);
    resp_en = 1'b0;
    repeat (15) @(negedge clk);
    play_upd = 1'b0;
    host_upd = 1'b0;
    busy = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    resp_en = re;
    slog.delete();
  endtask

  task automatic pulse(input logic p, input logic h);
    @(negedge clk);
    play_upd = p;
    host_upd = h;
    @(negedge clk);
    play_upd = 1'b0;
    host_upd = 1'b0;
  endtask

  initial begin
    int h;
    logic [127:0] er1, er2;
    // n, play_upd, host_upd, busy | start, owner, play_pend, host_pend, rows(0 sp,1 play,2 host)
    tbl[0]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{1, 1, 0, 0, 0, 0, 1, 0, 0};
    tbl[2]  = '{1, 0, 0, 0, 0, 0, 1, 0, 0};
    tbl[3]  = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
    tbl[4]  = '{1, 0, 0, 0, 0, 0, 0, 0, 1};
    tbl[5]  = '{3, 0, 0, 1, 0, 0, 0, 0, 1};
    tbl[6]  = '{1, 0, 0, 0, 0, 0, 0, 0, 1};
    tbl[7]  = '{1, 0, 1, 0, 0, 0, 0, 1, 1};
    tbl[8]  = '{15, 0, 0, 0, 0, 0, 0, 1, 1};
    tbl[9]  = '{1, 0, 0, 0, 1, 1, 0, 0, 2};
    tbl[10] = '{1, 0, 0, 0, 0, 1, 0, 0, 2};
    tbl[11] = '{2, 0, 0, 1, 0, 1, 0, 0, 2};
    tbl[12] = '{1, 0, 0, 0, 0, 1, 0, 0, 2};
    tbl[13] = '{3, 0, 0, 1, 0, 1, 0, 0, 2};
    do_reset(1'b0);
    chk("reset row1", lcd_row1, SP);
    chk("reset row2", lcd_row2, SP);
    chk("reset start", lcd_start, 1'b0);
    chk("reset owner", owner, 1'b0);
    chk("reset pend", {play_pend, host_pend}, 2'b00);
    for (int i = 0; i < 14; i++)
      for (int j = 0; j < tbl[i].n; j++) begin
        @(negedge clk);
        play_upd = tbl[i].pu;
        host_upd = tbl[i].hu;
        busy = tbl[i].bz;
        @(posedge clk);
        #1;
        er1 = tbl[i].rw == 0 ? SP : tbl[i].rw == 1 ? play_row1 : host_row1;
        er2 = tbl[i].rw == 0 ? SP : tbl[i].rw == 1 ? play_row2 : host_row2;
        chk($sformatf("v%0d.%0d start", i, j), lcd_start, tbl[i].st);
        chk($sformatf("v%0d.%0d owner", i, j), owner, tbl[i].ow);
        chk($sformatf("v%0d.%0d play_pend", i, j), play_pend, tbl[i].pp);
        chk($sformatf("v%0d.%0d host_pend", i, j), host_pend, tbl[i].hp);
        chk($sformatf("v%0d.%0d row1", i, j), lcd_row1, er1);
        chk($sformatf("v%0d.%0d row2", i, j), lcd_row2, er2);
      end
    busy = 1'b0;

    // simultaneous updates: player first, host only after the dwell
    do_reset(1'b1);
    pulse(1'b1, 1'b1);
    wait_log(2, 100, "rr starts");
    h = cyc;
    if (slog.size() >= 2) begin
      chk("rr first owner", slog[0].ow, 1'b0);
      chk("rr first row", slog[0].r1, play_row1);
      chk("rr second owner", slog[1].ow, 1'b1);
      chk("rr second row", slog[1].r1, host_row1);
      chk("rr dwell gap", slog[1].t - slog[0].t >= 20, 1'b1);
      h = slog[1].t;
    end

    // host self-refreshes during its dwell while the player waits
    repeat (14) @(negedge clk);
    host_row1 = "HOST-TOP-BBBBBBB";
    host_upd = 1'b1;
    play_upd = 1'b1;
    @(negedge clk);
    host_upd = 1'b0;
    play_upd = 1'b0;
    repeat (3) @(negedge clk);
    host_row1 = "HOST-TOP-CCCCCCC";
    host_upd = 1'b1;
    @(negedge clk);
    host_upd = 1'b0;
    repeat (3) @(negedge clk);
    host_row1 = "HOST-TOP-DDDDDDD";
    host_upd = 1'b1;
    @(negedge clk);
    host_upd = 1'b0;
    wait_log(5, 60, "refresh starts");
    if (slog.size() >= 5) begin
      chk("refresh1 owner", slog[2].ow, 1'b1);
      chk("refresh1 row", slog[2].r1, "HOST-TOP-BBBBBBB");
      chk("refresh2 owner", slog[3].ow, 1'b1);
      chk("refresh2 row", slog[3].r1, "HOST-TOP-DDDDDDD");
      chk("player after host owner", slog[4].ow, 1'b0);
      chk("player after host row", slog[4].r1, play_row1);
      chk("player wait bound", slog[4].t - h <= 60 && slog[4].t - h >= 20, 1'b1);
    end
    host_row1 = "HOST-TOP-AAAAAAA";

    // update coincident with the player latch cycle is kept and redrawn
    do_reset(1'b1);
    @(negedge clk);
    play_upd = 1'b1;
    @(negedge clk);
    play_upd = 1'b0;
    @(negedge clk);
    play_upd = 1'b1;
    @(posedge clk);
    #1;
    chk("coincident pend", play_pend, 1'b1);
    chk("coincident start", lcd_start, 1'b1);
    @(negedge clk);
    play_upd = 1'b0;
    wait_log(2, 60, "coincident redraw");
    if (slog.size() >= 2) begin
      chk("redraw owner", slog[1].ow, 1'b0);
      chk("redraw gap", slog[1].t - slog[0].t <= 20, 1'b1);
    end
    repeat (2) @(negedge clk);
    chk("redraw pend cleared", play_pend, 1'b0);

    // driver never acknowledges: start re-pulses every 17 cycles
    do_reset(1'b0);
    pulse(1'b1, 1'b0);
    wait_log(3, 100, "ack timeout starts");
    if (slog.size() >= 3) begin
      chk("retry period 1", slog[1].t - slog[0].t, 17);
      chk("retry period 2", slog[2].t - slog[1].t, 17);
      chk("retry row stable", slog[2].r1, play_row1);
    end

    // asynchronous reset while waiting for the acknowledge
    do_reset(1'b0);
    pulse(1'b1, 1'b0);
    wait_log(1, 20, "pre-reset start");
    pulse(1'b0, 1'b1);
    chk("pre-reset host_pend", host_pend, 1'b1);
    chk("pre-reset row1", lcd_row1, play_row1);
    #2 rst = 1'b1;
    #1;
    chk("async row1", lcd_row1, SP);
    chk("async row2", lcd_row2, SP);
    chk("async start", lcd_start, 1'b0);
    chk("async pend", {play_pend, host_pend}, 2'b00);
    chk("async owner", owner, 1'b0);
    #1 rst = 1'b0;
    slog.delete();
    repeat (20) @(negedge clk);
    chk("post-reset idle", slog.size(), 0);
    chk("post-reset rows", lcd_row1, SP);
    pulse(1'b0, 1'b1);
    wait_log(1, 10, "post-reset recovery");
    if (slog.size() >= 1) chk("recovery owner", slog[0].ow, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
